// File: rtl/if_stage.sv
// Instruction-fetch stage: keeps the PC, runs a single-outstanding request
// handshake to instruction memory and fills the IF/ID pipeline register.
// A one-entry skid register absorbs a response that lands while ID is stalled.
// Optional feature macro: IF_MISALIGN_CHECK_EN. When it is defined, a redirect
// to a target that is not word-aligned halts fetch and hands ID a flagged NOP.
// When it is undefined, the low two target bits are ignored.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_misalign
);

    localparam logic [2:0] ST_REQ  = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_DROP = 3'd3;
`ifdef IF_MISALIGN_CHECK_EN
    localparam logic [2:0] ST_HALT = 3'd4;
`endif
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [2:0]  state_reg,       state_next;
    logic [31:0] pc_reg,          pc_next;
    logic        id_valid_reg,    id_valid_next;
    logic [31:0] id_inst_reg,     id_inst_next;
    logic [31:0] id_pc_reg,       id_pc_next;
    logic        id_misalign_reg, id_misalign_next;
    logic [31:0] skid_inst_reg,   skid_inst_next;
    logic [31:0] skid_pc_reg,     skid_pc_next;

    logic [31:0] redirect_target;
    logic [31:0] pc_inc;
    logic        bubble;

`ifdef IF_MISALIGN_CHECK_EN
    assign redirect_target = redirect_pc;
`else
    // Low bits are dropped so the fetch address is always word aligned.
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
`endif

    // Natural 32-bit wrap takes 32'hFFFF_FFFC back to zero.
    assign pc_inc = pc_reg + 32'd4;

    assign imem_req    = (state_reg == ST_REQ);
    assign imem_addr   = pc_reg;
    assign id_valid    = id_valid_reg;
    assign id_inst     = id_inst_reg;
    assign id_pc       = id_pc_reg;
    assign id_pc4      = id_pc_reg + 32'd4;
    assign id_misalign = id_misalign_reg;

    // Next-state logic: redirect first, then the normal fetch handshake.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        id_valid_next    = id_valid_reg;
        id_inst_next     = id_inst_reg;
        id_pc_next       = id_pc_reg;
        id_misalign_next = id_misalign_reg;
        skid_inst_next   = skid_inst_reg;
        skid_pc_next     = skid_pc_reg;
        bubble           = 1'b0;

        if (redirect) begin
            pc_next          = redirect_target;
            id_valid_next    = 1'b0;
            id_misalign_next = 1'b0;
            skid_inst_next   = NOP_INST;
            skid_pc_next     = 32'h0;
            case (state_reg)
                // An accepted request still owes a response that must be eaten.
                ST_REQ:  state_next = imem_ready  ? ST_DROP : ST_REQ;
                ST_WAIT: state_next = imem_rvalid ? ST_REQ  : ST_DROP;
                ST_DROP: state_next = imem_rvalid ? ST_REQ  : ST_DROP;
                default: state_next = ST_REQ;
            endcase
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (imem_ready) state_next = ST_WAIT;
                    bubble = 1'b1;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        pc_next    = pc_inc;
                        state_next = ST_REQ;
                        if (!stall || !id_valid_reg) begin
                            id_valid_next    = 1'b1;
                            id_inst_next     = imem_rdata;
                            id_pc_next       = pc_reg;
                            id_misalign_next = 1'b0;
                        end else begin
                            // ID is stuck on a live instruction: park the word.
                            skid_inst_next = imem_rdata;
                            skid_pc_next   = pc_reg;
                            state_next     = ST_HOLD;
                        end
                    end else begin
                        bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        id_valid_next    = 1'b1;
                        id_inst_next     = skid_inst_reg;
                        id_pc_next       = skid_pc_reg;
                        id_misalign_next = 1'b0;
                        state_next       = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) state_next = ST_REQ;
                    bubble = 1'b1;
                end
`ifdef IF_MISALIGN_CHECK_EN
                ST_HALT: bubble = 1'b1;
`endif
                default: state_next = ST_REQ;
            endcase

            // Nothing new for ID and ID is consuming: present a bubble.
            if (bubble && !stall) begin
                id_valid_next    = 1'b0;
                id_misalign_next = 1'b0;
            end
        end

`ifdef IF_MISALIGN_CHECK_EN
        // Misaligned target: no fetch, report a flagged NOP and park in HALT.
        // Any response still in flight is ignored while halted.
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            state_next       = ST_HALT;
            id_valid_next    = 1'b1;
            id_inst_next     = NOP_INST;
            id_pc_next       = redirect_pc;
            id_misalign_next = 1'b1;
        end
`endif
    end

    // State registers with synchronous reset; reset wins over redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_REQ;
            pc_reg          <= RESET_PC;
            id_valid_reg    <= 1'b0;
            id_inst_reg     <= NOP_INST;
            id_pc_reg       <= 32'h0;
            id_misalign_reg <= 1'b0;
            skid_inst_reg   <= NOP_INST;
            skid_pc_reg     <= 32'h0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            id_valid_reg    <= id_valid_next;
            id_inst_reg     <= id_inst_next;
            id_pc_reg       <= id_pc_next;
            id_misalign_reg <= id_misalign_next;
            skid_inst_reg   <= skid_inst_next;
            skid_pc_reg     <= skid_pc_next;
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hazard hold; ID does not consume id_* this cycle.
REQ-005 redirect  input  1  branch/jump taken; flush fetch and restart at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch target.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  fetch address (= current PC).
REQ-009 imem_ready  input  1  request accepted this cycle when imem_req=1.
REQ-010 imem_rvalid  input  1  read data valid; earliest the cycle after acceptance.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 id_inst  output  32  instruction to decoder.
REQ-014 id_pc  output  32  PC of id_inst.
REQ-015 id_pc4  output  32  id_pc + 4, modulo 2^32.
REQ-016 id_misalign  output  1  misaligned redirect target flag (see Configuration).

Function
REQ-017 At most one imem request outstanding.
REQ-018 States: REQ (imem_req=1, imem_addr=pc), WAIT (awaiting rvalid), HOLD (response parked in skid register), DROP (discard one stale response), HALT (configuration only).
REQ-019 REQ: imem_ready=1 -> WAIT; otherwise remain, imem_addr stable.
REQ-020 WAIT, rvalid=1, (stall=0 or id_valid=0): load id_inst=imem_rdata, id_pc=pc, id_valid=1; pc <= pc+4; -> REQ.
REQ-021 WAIT, rvalid=1, stall=1, id_valid=1: write rdata and pc to skid register; pc <= pc+4; -> HOLD; IF/ID unchanged.
REQ-022 HOLD: on stall=0, move skid into IF/ID (id_valid=1), -> REQ; no imem_req in HOLD.
REQ-023 No new instruction and stall=0: id_valid <= 0 (bubble); stall=1 holds all id_* unchanged.
REQ-024 redirect=1 has priority over every other event: pc <= redirect_pc; id_valid <= 0; skid cleared.
REQ-025 Redirect in WAIT without rvalid, or in REQ with imem_ready=1 same cycle -> DROP; DROP discards the next rvalid, then -> REQ.
REQ-026 Redirect in WAIT coincident with rvalid: data discarded, -> REQ.
REQ-027 Redirect in REQ (not accepted), HOLD, or DROP-with-rvalid -> REQ; redirect in DROP without rvalid stays in DROP.
REQ-028 PC increment wraps 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-029 rst=1: state=REQ, pc=RESET_PC, id_valid=0, id_inst=32'h0000_0013, id_pc=0, id_misalign=0, skid empty; rst overrides redirect.
REQ-030 imem_req=1 with imem_addr=RESET_PC in the first cycle after rst deasserts; a response pending at reset is not tracked (memory flushed together with core).

Configuration
REQ-031 Macro IF_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 issues no request; next cycle id_valid=1, id_inst=32'h0000_0013, id_pc=redirect_pc, id_misalign=1; state HALT (no imem_req) until the next redirect.
REQ-032 Macro undefined: redirect_pc[1:0] forced to 2'b00; id_misalign tied 0; HALT absent.

Verification
REQ-033 Reset release, imem_ready=1, rvalid one cycle later with 32'h00500093 -> id_valid=1, id_inst=32'h00500093, id_pc=0, id_pc4=4; next imem_addr=4.
REQ-034 stall=1 with id_valid=1 while rvalid arrives (addr 8) -> IF/ID unchanged, state HOLD; stall drops -> id_pc=8 next cycle, imem_addr=12.
REQ-035 Redirect to 32'h100 while WAIT on addr 4, rvalid next cycle -> response discarded (id_valid stays 0), next imem_addr=32'h100.
REQ-036 Redirect to 32'h200 same cycle as rvalid -> no IF/ID load, imem_req with addr 32'h200 next cycle.
REQ-037 PC=32'hFFFF_FFFC fetched -> id_pc4=0, next imem_addr=0.
REQ-038 With IF_MISALIGN_CHECK_EN, redirect to 32'h102 -> id_misalign=1, id_pc=32'h102, imem_req=0 until a redirect to 32'h104.
